// File: rtl/issue_dispatch_ctrl.sv
// Dual-issue dispatch controller: buffers one decoded instruction pair and writes
// it in order into the add and multiply reservation stations.
module issue_dispatch_ctrl #(
   parameter int ADD_RS_DEPTH = 3,
   parameter int MUL_RS_DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_type0,
   input  logic [7:0] in_dest0,
   input  logic [7:0] in_src0a,
   input  logic [7:0] in_src0b,
   input  logic [7:0] in_type1,
   input  logic [7:0] in_dest1,
   input  logic [7:0] in_src1a,
   input  logic [7:0] in_src1b,
   input  logic       flush,
   input  logic       add_rs_release,
   input  logic       mul_rs_release,
   output logic       ars_issue,
   output logic [7:0] ars_type,
   output logic [7:0] ars_dest,
   output logic [7:0] ars_src_a,
   output logic [7:0] ars_src_b,
   output logic       mrs_issue,
   output logic [7:0] mrs_type,
   output logic [7:0] mrs_dest,
   output logic [7:0] mrs_src_a,
   output logic [7:0] mrs_src_b,
   output logic       AR_Status,
   output logic       MR_Status,
   output logic       err_illegal
);

   localparam int AW = $clog2(ADD_RS_DEPTH + 1);
   localparam int MW = $clog2(MUL_RS_DEPTH + 1);
   localparam logic [AW-1:0] ADD_FULL = AW'(ADD_RS_DEPTH);
   localparam logic [MW-1:0] MUL_FULL = MW'(MUL_RS_DEPTH);

   localparam logic [1:0] CL_NOP = 2'd0;
   localparam logic [1:0] CL_ADD = 2'd1;
   localparam logic [1:0] CL_MUL = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_TWO   = 2'd1,
      ST_ONE   = 2'd2
   } state_t;

   function automatic logic [1:0] decode_class(input logic [7:0] t);
      case (t)
         8'h01, 8'h02: decode_class = CL_ADD;
         8'h03, 8'h04: decode_class = CL_MUL;
         default:      decode_class = CL_NOP;
      endcase
   endfunction

   function automatic logic is_illegal(input logic [7:0] t);
      is_illegal = (t > 8'h04);
   endfunction

   state_t        state_q, state_d;
   logic [7:0]    s0_type_q, s0_dest_q, s0_srca_q, s0_srcb_q;
   logic [7:0]    s0_type_d, s0_dest_d, s0_srca_d, s0_srcb_d;
   logic [7:0]    s1_type_q, s1_dest_q, s1_srca_q, s1_srcb_q;
   logic [7:0]    s1_type_d, s1_dest_d, s1_srca_d, s1_srcb_d;
   logic [AW-1:0] add_free_q, add_free_d;
   logic [MW-1:0] mul_free_q, mul_free_d;
   logic          err_q, err_d;

   logic [1:0] cls0, cls1;
   logic       avail0, avail1, active, go0, go1, accept;
   logic       add_iss0, add_iss1, mul_iss0, mul_iss1;
   logic       add_rel_ok, mul_rel_ok, add_sat_err, mul_sat_err, illegal_retire;

   assign cls0   = decode_class(s0_type_q);
   assign cls1   = decode_class(s1_type_q);
   assign avail0 = (cls0 == CL_NOP) || (cls0 == CL_ADD && add_free_q != '0) ||
                   (cls0 == CL_MUL && mul_free_q != '0);
   assign avail1 = (cls1 == CL_NOP) || (cls1 == CL_ADD && add_free_q != '0) ||
                   (cls1 == CL_MUL && mul_free_q != '0);
   assign active = !reset && !flush;

   // The younger slot may only ride along if it does not compete with slot0 for an RS.
   assign go0 = active && (state_q == ST_TWO) && avail0;
   assign go1 = active && (((state_q == ST_TWO) && go0 &&
                            ((cls1 == CL_NOP) || ((cls1 != cls0) && avail1))) ||
                           ((state_q == ST_ONE) && avail1));

   assign add_iss0  = go0 && (cls0 == CL_ADD);
   assign add_iss1  = go1 && (cls1 == CL_ADD);
   assign mul_iss0  = go0 && (cls0 == CL_MUL);
   assign mul_iss1  = go1 && (cls1 == CL_MUL);
   assign ars_issue = add_iss0 || add_iss1;
   assign mrs_issue = mul_iss0 || mul_iss1;

   assign in_ready  = active && (state_q == ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign AR_Status = !reset && (add_free_q == '0);
   assign MR_Status = !reset && (mul_free_q == '0);
   assign err_illegal = err_q;

   // Release checks look at the current count only; a release at full is dropped.
   assign add_rel_ok     = add_rs_release && (add_free_q != ADD_FULL);
   assign mul_rel_ok     = mul_rs_release && (mul_free_q != MUL_FULL);
   assign add_sat_err    = add_rs_release && (add_free_q == ADD_FULL);
   assign mul_sat_err    = mul_rs_release && (mul_free_q == MUL_FULL);
   assign illegal_retire = (go0 && is_illegal(s0_type_q)) || (go1 && is_illegal(s1_type_q));

   // RS write port field muxes
   always_comb begin
      ars_type  = 8'h00;
      ars_dest  = 8'h00;
      ars_src_a = 8'h00;
      ars_src_b = 8'h00;
      mrs_type  = 8'h00;
      mrs_dest  = 8'h00;
      mrs_src_a = 8'h00;
      mrs_src_b = 8'h00;
      if (add_iss0) begin
         ars_type = s0_type_q; ars_dest = s0_dest_q; ars_src_a = s0_srca_q; ars_src_b = s0_srcb_q;
      end else if (add_iss1) begin
         ars_type = s1_type_q; ars_dest = s1_dest_q; ars_src_a = s1_srca_q; ars_src_b = s1_srcb_q;
      end else begin
         ars_type = 8'h00;
      end
      if (mul_iss0) begin
         mrs_type = s0_type_q; mrs_dest = s0_dest_q; mrs_src_a = s0_srca_q; mrs_src_b = s0_srcb_q;
      end else if (mul_iss1) begin
         mrs_type = s1_type_q; mrs_dest = s1_dest_q; mrs_src_a = s1_srca_q; mrs_src_b = s1_srcb_q;
      end else begin
         mrs_type = 8'h00;
      end
   end

   // Next-state, buffer load, free counters and sticky error
   always_comb begin
      state_d   = state_q;
      s0_type_d = s0_type_q; s0_dest_d = s0_dest_q; s0_srca_d = s0_srca_q; s0_srcb_d = s0_srcb_q;
      s1_type_d = s1_type_q; s1_dest_d = s1_dest_q; s1_srca_d = s1_srca_q; s1_srcb_d = s1_srcb_q;
      case (state_q)
         ST_EMPTY: state_d = accept ? ST_TWO : ST_EMPTY;
         ST_TWO:   state_d = go0 ? (go1 ? ST_EMPTY : ST_ONE) : ST_TWO;
         ST_ONE:   state_d = go1 ? ST_EMPTY : ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         state_d = state_d;
      end
      if (accept) begin
         s0_type_d = in_type0; s0_dest_d = in_dest0; s0_srca_d = in_src0a; s0_srcb_d = in_src0b;
         s1_type_d = in_type1; s1_dest_d = in_dest1; s1_srca_d = in_src1a; s1_srcb_d = in_src1b;
      end else begin
         s0_type_d = s0_type_q;
      end
      add_free_d = add_free_q - AW'(ars_issue) + AW'(add_rel_ok);
      mul_free_d = mul_free_q - MW'(mrs_issue) + MW'(mul_rel_ok);
      err_d      = err_q || illegal_retire || add_sat_err || mul_sat_err;
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         s0_type_q  <= 8'h00; s0_dest_q <= 8'h00; s0_srca_q <= 8'h00; s0_srcb_q <= 8'h00;
         s1_type_q  <= 8'h00; s1_dest_q <= 8'h00; s1_srca_q <= 8'h00; s1_srcb_q <= 8'h00;
         add_free_q <= ADD_FULL;
         mul_free_q <= MUL_FULL;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         s0_type_q  <= s0_type_d; s0_dest_q <= s0_dest_d; s0_srca_q <= s0_srca_d; s0_srcb_q <= s0_srcb_d;
         s1_type_q  <= s1_type_d; s1_dest_q <= s1_dest_d; s1_srca_q <= s1_srca_d; s1_srcb_q <= s1_srcb_d;
         add_free_q <= add_free_d;
         mul_free_q <= mul_free_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Bench for issue_dispatch_ctrl: directed scenarios plus a randomized run scored
// against an in-order instruction-queue reference model.
module tb_issue_dispatch_ctrl;

   localparam int ADD_D = 3;
   localparam int MUL_D = 2;

   logic clk = 1'b0;
   logic reset, in_valid, in_ready, flush, add_rs_release, mul_rs_release;
   logic [7:0] in_type0, in_dest0, in_src0a, in_src0b;
   logic [7:0] in_type1, in_dest1, in_src1a, in_src1b;
   logic ars_issue, mrs_issue, AR_Status, MR_Status, err_illegal;
   logic [7:0] ars_type, ars_dest, ars_src_a, ars_src_b;
   logic [7:0] mrs_type, mrs_dest, mrs_src_a, mrs_src_b;

   int checks = 0;
   int errors = 0;

   typedef struct packed { logic [7:0] t, d, a, b; } ins_t;

   issue_dispatch_ctrl #(.ADD_RS_DEPTH(ADD_D), .MUL_RS_DEPTH(MUL_D)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_type0(in_type0), .in_dest0(in_dest0), .in_src0a(in_src0a), .in_src0b(in_src0b),
      .in_type1(in_type1), .in_dest1(in_dest1), .in_src1a(in_src1a), .in_src1b(in_src1b),
      .flush(flush), .add_rs_release(add_rs_release), .mul_rs_release(mul_rs_release),
      .ars_issue(ars_issue), .ars_type(ars_type), .ars_dest(ars_dest),
      .ars_src_a(ars_src_a), .ars_src_b(ars_src_b),
      .mrs_issue(mrs_issue), .mrs_type(mrs_type), .mrs_dest(mrs_dest),
      .mrs_src_a(mrs_src_a), .mrs_src_b(mrs_src_b),
      .AR_Status(AR_Status), .MR_Status(MR_Status), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; flush = 1'b0; add_rs_release = 1'b0; mul_rs_release = 1'b0;
      in_type0 = 8'h00; in_dest0 = 8'h00; in_src0a = 8'h00; in_src0b = 8'h00;
      in_type1 = 8'h00; in_dest1 = 8'h00; in_src1a = 8'h00; in_src1b = 8'h00;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic load_pair(input ins_t i0, input ins_t i1);
      in_type0 = i0.t; in_dest0 = i0.d; in_src0a = i0.a; in_src0b = i0.b;
      in_type1 = i1.t; in_dest1 = i1.d; in_src1a = i1.a; in_src1b = i1.b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      #1;
      checks++;
      if (in_ready !== 1'b0 || ars_issue !== 1'b0 || mrs_issue !== 1'b0 ||
          AR_Status !== 1'b0 || MR_Status !== 1'b0 || err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b ars=%b mrs=%b ar=%b mr=%b err=%b, required all 0",
                  in_ready, ars_issue, mrs_issue, AR_Status, MR_Status, err_illegal);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || int'(dut.add_free_q) != ADD_D || int'(dut.mul_free_q) != MUL_D) begin
         errors++;
         $display("FAIL reset_release: rdy=%b add_free=%0d mul_free=%0d, required 1/%0d/%0d",
                  in_ready, dut.add_free_q, dut.mul_free_q, ADD_D, MUL_D);
      end
   endtask

   task automatic test_add_mul_pair();
      do_reset();
      load_pair('{8'h01, 8'd1, 8'd2, 8'd3}, '{8'h03, 8'd4, 8'd5, 8'd6});
      checks++;
      if (ars_issue !== 1'b1 || ars_dest !== 8'd1 || ars_src_a !== 8'd2 || ars_src_b !== 8'd3 ||
          mrs_issue !== 1'b1 || mrs_type !== 8'h03 || mrs_dest !== 8'd4 || mrs_src_b !== 8'd6) begin
         errors++;
         $display("FAIL add_mul_issue: ars=%b d=%0d mrs=%b t=%h d=%0d, required 1/1, 1/03/4",
                  ars_issue, ars_dest, mrs_issue, mrs_type, mrs_dest);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || int'(dut.add_free_q) != 2 || int'(dut.mul_free_q) != 1 ||
          ars_issue !== 1'b0 || ars_dest !== 8'h00) begin
         errors++;
         $display("FAIL add_mul_after: rdy=%b add=%0d mul=%0d ars=%b, required 1/2/1/0",
                  in_ready, dut.add_free_q, dut.mul_free_q, ars_issue);
      end
   endtask

   task automatic test_add_sub();
      do_reset();
      load_pair('{8'h01, 8'd7, 8'd8, 8'd9}, '{8'h02, 8'd10, 8'd11, 8'd12});
      checks++;
      if (ars_issue !== 1'b1 || ars_type !== 8'h01 || ars_dest !== 8'd7 || mrs_issue !== 1'b0) begin
         errors++;
         $display("FAIL add_sub_c1: ars=%b t=%h d=%0d mrs=%b, required 1/01/7/0",
                  ars_issue, ars_type, ars_dest, mrs_issue);
      end
      tick();
      checks++;
      if (ars_issue !== 1'b1 || ars_type !== 8'h02 || ars_dest !== 8'd10 || in_ready !== 1'b0 ||
          int'(dut.add_free_q) != 2) begin
         errors++;
         $display("FAIL add_sub_c2: ars=%b t=%h d=%0d rdy=%b add=%0d, required 1/02/10/0/2",
                  ars_issue, ars_type, ars_dest, in_ready, dut.add_free_q);
      end
      tick();
      checks++;
      if (int'(dut.add_free_q) != 1 || in_ready !== 1'b1 || ars_issue !== 1'b0) begin
         errors++;
         $display("FAIL add_sub_end: add=%0d rdy=%b ars=%b, required 1/1/0",
                  dut.add_free_q, in_ready, ars_issue);
      end
   endtask

   task automatic test_mul_stall();
      do_reset();
      load_pair('{8'h03, 8'd1, 8'd1, 8'd1}, '{8'h04, 8'd2, 8'd2, 8'd2});
      tick();
      tick();
      checks++;
      if (MR_Status !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mul_full: mr=%b rdy=%b, required 1/1", MR_Status, in_ready);
      end
      load_pair('{8'h03, 8'd9, 8'd3, 8'd4}, '{8'h00, 8'd0, 8'd0, 8'd0});
      tick();
      checks++;
      if (mrs_issue !== 1'b0 || in_ready !== 1'b0 || MR_Status !== 1'b1) begin
         errors++;
         $display("FAIL mul_stall: mrs=%b rdy=%b mr=%b, required 0/0/1", mrs_issue, in_ready, MR_Status);
      end
      mul_rs_release = 1'b1;
      #1;
      checks++;
      if (mrs_issue !== 1'b0) begin
         errors++;
         $display("FAIL mul_release_bypass: mrs=%b, required 0", mrs_issue);
      end
      tick();
      mul_rs_release = 1'b0;
      #1;
      checks++;
      if (mrs_issue !== 1'b1 || mrs_dest !== 8'd9 || mrs_src_a !== 8'd3 || MR_Status !== 1'b0) begin
         errors++;
         $display("FAIL mul_after_release: mrs=%b d=%0d a=%0d mr=%b, required 1/9/3/0",
                  mrs_issue, mrs_dest, mrs_src_a, MR_Status);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      load_pair('{8'h07, 8'd1, 8'd1, 8'd1}, '{8'h01, 8'd5, 8'd6, 8'd7});
      checks++;
      if (ars_issue !== 1'b1 || ars_type !== 8'h01 || ars_dest !== 8'd5 || mrs_issue !== 1'b0 ||
          err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_issue: ars=%b t=%h d=%0d mrs=%b err=%b, required 1/01/5/0/0",
                  ars_issue, ars_type, ars_dest, mrs_issue, err_illegal);
      end
      tick();
      tick();
      tick();
      checks++;
      if (err_illegal !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL illegal_sticky: err=%b rdy=%b, required 1/1", err_illegal, in_ready);
      end
      do_reset();
      checks++;
      if (err_illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear: err=%b, required 0", err_illegal);
      end
   endtask

   task automatic test_flush_reset();
      do_reset();
      load_pair('{8'h01, 8'd1, 8'd0, 8'd0}, '{8'h02, 8'd2, 8'd0, 8'd0});
      tick();
      tick();
      load_pair('{8'h01, 8'd3, 8'd0, 8'd0}, '{8'h03, 8'd4, 8'd0, 8'd0});
      tick();
      load_pair('{8'h02, 8'd5, 8'd0, 8'd0}, '{8'h00, 8'd0, 8'd0, 8'd0});
      checks++;
      if (ars_issue !== 1'b0 || in_ready !== 1'b0 || AR_Status !== 1'b1) begin
         errors++;
         $display("FAIL stall_two: ars=%b rdy=%b ar=%b, required 0/0/1", ars_issue, in_ready, AR_Status);
      end
      flush = 1'b1;
      add_rs_release = 1'b1;
      in_valid = 1'b1;
      #1;
      checks++;
      if (ars_issue !== 1'b0 || mrs_issue !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_strobes: ars=%b mrs=%b rdy=%b, required 0/0/0", ars_issue, mrs_issue, in_ready);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (in_ready !== 1'b1 || int'(dut.add_free_q) != 1 || ars_issue !== 1'b0 || AR_Status !== 1'b0) begin
         errors++;
         $display("FAIL flush_after: rdy=%b add=%0d ars=%b ar=%b, required 1/1/0/0",
                  in_ready, dut.add_free_q, ars_issue, AR_Status);
      end
      load_pair('{8'h01, 8'd6, 8'd0, 8'd0}, '{8'h01, 8'd7, 8'd0, 8'd0});
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || ars_issue !== 1'b0 || AR_Status !== 1'b0 || ars_dest !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_stall: rdy=%b ars=%b ar=%b d=%0d, required 0/0/0/0",
                  in_ready, ars_issue, AR_Status, ars_dest);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || int'(dut.add_free_q) != ADD_D || int'(dut.mul_free_q) != MUL_D) begin
         errors++;
         $display("FAIL reset_recover: rdy=%b add=%0d mul=%0d, required 1/3/2",
                  in_ready, dut.add_free_q, dut.mul_free_q);
      end
   endtask

   function automatic int mcls(input logic [7:0] t);
      if (t == 8'h01 || t == 8'h02) return 1;
      if (t == 8'h03 || t == 8'h04) return 2;
      return 0;
   endfunction

   function automatic logic [7:0] pick_type();
      case ($urandom_range(0, 7))
         0: return 8'h00;
         1: return 8'h01;
         2: return 8'h02;
         3: return 8'h03;
         4: return 8'h04;
         5: return 8'h07;
         6: return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic test_random();
      ins_t q[$];
      ins_t ea, em, n0, n1;
      int m_add, m_mul, n_ret, c0, c1, old_add, old_mul;
      bit m_err, e_ready, e_ars, e_mrs;
      do_reset();
      q.delete();
      m_add = ADD_D; m_mul = MUL_D; m_err = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         reset = ($urandom_range(0, 59) == 0);
         flush = ($urandom_range(0, 24) == 0);
         in_valid = 1'($urandom_range(0, 1));
         add_rs_release = ($urandom_range(0, 3) == 0);
         mul_rs_release = ($urandom_range(0, 3) == 0);
         n0 = '{pick_type(), 8'($urandom), 8'($urandom), 8'($urandom)};
         n1 = '{pick_type(), 8'($urandom), 8'($urandom), 8'($urandom)};
         in_type0 = n0.t; in_dest0 = n0.d; in_src0a = n0.a; in_src0b = n0.b;
         in_type1 = n1.t; in_dest1 = n1.d; in_src1a = n1.a; in_src1b = n1.b;
         #1;
         e_ready = !reset && !flush && (q.size() == 0);
         n_ret = 0;
         if (!reset && !flush && q.size() > 0) begin
            c0 = mcls(q[0].t);
            if (c0 == 0 || (c0 == 1 ? m_add > 0 : m_mul > 0)) begin
               n_ret = 1;
               if (q.size() == 2) begin
                  c1 = mcls(q[1].t);
                  if (c1 == 0 || (c1 != c0 && (c1 == 1 ? m_add > 0 : m_mul > 0))) n_ret = 2;
               end
            end
         end
         ea = '0; em = '0; e_ars = 1'b0; e_mrs = 1'b0;
         for (int i = 0; i < n_ret; i++) begin
            if (mcls(q[i].t) == 1) begin ea = q[i]; e_ars = 1'b1; end
            if (mcls(q[i].t) == 2) begin em = q[i]; e_mrs = 1'b1; end
         end
         checks++;
         if (in_ready !== e_ready || ars_issue !== e_ars || mrs_issue !== e_mrs ||
             {ars_type, ars_dest, ars_src_a, ars_src_b} !== ea ||
             {mrs_type, mrs_dest, mrs_src_a, mrs_src_b} !== em) begin
            errors++;
            $display("FAIL rand_issue cyc %0d: rdy=%b ars=%b %h mrs=%b %h, required %b %b %h %b %h",
                     cyc, in_ready, ars_issue, {ars_type, ars_dest, ars_src_a, ars_src_b},
                     mrs_issue, {mrs_type, mrs_dest, mrs_src_a, mrs_src_b},
                     e_ready, e_ars, ea, e_mrs, em);
         end
         checks++;
         if (AR_Status !== (!reset && m_add == 0) || MR_Status !== (!reset && m_mul == 0) ||
             err_illegal !== m_err) begin
            errors++;
            $display("FAIL rand_status cyc %0d: ar=%b mr=%b err=%b, required free %0d/%0d err %b",
                     cyc, AR_Status, MR_Status, err_illegal, m_add, m_mul, m_err);
         end
         @(posedge clk);
         if (reset) begin
            q.delete();
            m_add = ADD_D; m_mul = MUL_D; m_err = 1'b0;
         end else begin
            old_add = m_add; old_mul = m_mul;
            for (int i = 0; i < n_ret; i++) begin
               if (q[0].t > 8'h04) m_err = 1'b1;
               if (mcls(q[0].t) == 1) m_add--;
               if (mcls(q[0].t) == 2) m_mul--;
               void'(q.pop_front());
            end
            if (add_rs_release) begin
               if (old_add == ADD_D) m_err = 1'b1; else m_add++;
            end
            if (mul_rs_release) begin
               if (old_mul == MUL_D) m_err = 1'b1; else m_mul++;
            end
            if (flush) q.delete();
            if (e_ready && in_valid) begin
               q.push_back(n0);
               q.push_back(n1);
            end
         end
         #1;
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_add_mul_pair();
      test_add_sub();
      test_mul_stall();
      test_illegal();
      test_flush_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_dispatch_ctrl.md
ISSUE_DISPATCH_CTRL -- requirements
Module: issue_dispatch_ctrl

Interface
REQ-001 SHALL have parameters: ADD_RS_DEPTH, default 3, add reservation-station entries; MUL_RS_DEPTH, default 2, multiply reservation-station entries.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: decoded-pair handshake.
REQ-005 SHALL have ports in_type0/in_dest0/in_src0a/in_src0b  input  8 each: older instruction fields.
REQ-006 SHALL have ports in_type1/in_dest1/in_src1a/in_src1b  input  8 each: younger instruction fields.
REQ-007 SHALL have ports flush input 1 (discard buffer), add_rs_release input 1, mul_rs_release input 1 (one RS entry freed this cycle).
REQ-008 SHALL have ports ars_issue output 1, ars_type/ars_dest/ars_src_a/ars_src_b output 8 each: add-RS write.
REQ-009 SHALL have ports mrs_issue output 1, mrs_type/mrs_dest/mrs_src_a/mrs_src_b output 8 each: multiply-RS write.
REQ-010 SHALL have ports AR_Status output 1 (add RS full), MR_Status output 1 (mul RS full), err_illegal output 1 (sticky).

Function
REQ-011 SHALL decode type: 8'h01 ADD, 8'h02 SUB -> add class; 8'h03 MUL, 8'h04 DIV -> mul class; 8'h00 NOP; any other value -> illegal, handled as NOP.
REQ-012 SHALL hold a 2-slot in-order buffer, slot0 older; states EMPTY, TWO (both slots pending), ONE (only slot1 pending).
REQ-013 SHALL drive in_ready = 1 only in EMPTY and flush = 0; pair accepted on edge where in_valid && in_ready, EMPTY -> TWO.
REQ-014 SHALL evaluate issue combinationally from buffer and free counters during the cycle after acceptance (minimum latency one cycle).
REQ-015 SHALL, in TWO, issue slot0 when its class counter > 0 (NOP/illegal always retire); slot1 issues same cycle only if slot0 retires and slot1 is NOP/illegal or its class differs from slot0's with counter > 0.
REQ-016 SHALL transition TWO -> EMPTY when both retire, TWO -> ONE when only slot0 retires, TWO -> TWO when slot0 stalls; slot1 never retires before slot0.
REQ-017 SHALL, in ONE, issue slot1 when its class counter > 0 or it is NOP/illegal, then ONE -> EMPTY; else stay ONE.
REQ-018 SHALL assert at most one ars_issue and one mrs_issue per cycle, fields copied unmodified from the issuing slot; fields read 8'h00 when issue strobe low.
REQ-019 SHALL keep add_free in 0..ADD_RS_DEPTH, mul_free in 0..MUL_RS_DEPTH: next = free - issue + release; issue checks only current value (release not bypassed same cycle).
REQ-020 SHALL ignore a release when counter already at depth (saturate) and set err_illegal.
REQ-021 SHALL drive AR_Status = (add_free == 0), MR_Status = (mul_free == 0) from registered counters.
REQ-022 SHALL set err_illegal on the edge an illegal type retires; cleared only by reset.
REQ-023 SHALL, on flush, force all issue strobes low that cycle and return to EMPTY on the edge; counters still apply releases; in_valid ignored during flush.

Reset
REQ-024 SHALL, with reset high at an edge, set state EMPTY, add_free = ADD_RS_DEPTH, mul_free = MUL_RS_DEPTH, err_illegal = 0; reset overrides flush, release and accept.
REQ-025 SHALL hold all issue strobes and fields at 0, AR_Status = MR_Status = 0, in_ready = 0 while reset is high; in_ready = 1 the cycle after reset deasserts.

Verification
REQ-026 Pair ADD r1,r2,r3 / MUL r4,r5,r6 into EMPTY -> next cycle ars_issue = mrs_issue = 1, state EMPTY, add_free = 2, mul_free = 1.
REQ-027 Pair ADD / SUB -> cycle 1 ars_issue for ADD only, state ONE; cycle 2 ars_issue for SUB; add_free 3 -> 2 -> 1.
REQ-028 Three MUL pairs without release -> MR_Status = 1 after mul_free reaches 0; MUL held in buffer, in_ready = 0; one mul_rs_release -> MUL issues the following cycle, not the same cycle.
REQ-029 Pair type 8'h07 / ADD -> both retire in one cycle, ars_issue for ADD, err_illegal = 1 and stays 1 until reset.
REQ-030 Buffer stalled in TWO, flush with add_rs_release -> no issue strobes, state EMPTY, add_free +1; reset mid-stall -> counters back to 3/2, in_ready = 1 after reset drops.
